// File: rtl/cos_datapath.sv
// Fixed-point datapath for the Taylor-series cosine accelerator: holds x^2, the
// running term t, the accumulated result r and the term counter, driven by FSM strobes.
module cos_datapath #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned NTERMS = 8,
  parameter int unsigned THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] xbus,
  input  logic             ldx,
  input  logic             ld1,
  input  logic             ld0cnt,
  input  logic             ldt,
  input  logic             xsel,
  input  logic             rsel,
  input  logic             ldr,
  input  logic             addsub,
  input  logic             en,
  input  logic             inccnt,
  output logic             TLTY,
  output logic             repcnt0,
  output logic [WIDTH-1:0] rbus
);

  localparam int unsigned CW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]           CNT_MAX = CW'(NTERMS - 1);

  // Signed fixed-point multiply: floor shift by FRAC, then clamp to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] mul_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    p = p >>> FRAC;
    if (p > PW'(SMAX))      return SMAX;
    else if (p < PW'(SMIN)) return SMIN;
    else                    return WIDTH'(p);
  endfunction

  function automatic logic signed [WIDTH-1:0] add_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b,
                                                      input logic                    add);
    logic signed [WIDTH:0] s;
    s = add ? ((WIDTH+1)'(a) + (WIDTH+1)'(b)) : ((WIDTH+1)'(a) - (WIDTH+1)'(b));
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
    else                        return WIDTH'(s);
  endfunction

  // 1/((2k+1)(2k+2)) in Q.FRAC, rounded to nearest.
  function automatic logic signed [WIDTH-1:0] coef_f(input int unsigned k);
    int unsigned d;
    int unsigned one_i;
    d     = (2 * k + 1) * (2 * k + 2);
    one_i = 1 << FRAC;
    return WIDTH'((one_i + d / 2) / d);
  endfunction

  logic signed [WIDTH-1:0] xsq_q, xsq_d;
  logic signed [WIDTH-1:0] t_q, t_d;
  logic signed [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] coef_rom [NTERMS];
  logic signed [WIDTH-1:0] op;
  logic [WIDTH-1:0]        abs_t;
  logic                    t_is_min;
  logic                    unused_en;

  // en is a status strobe only; the datapath ignores it.
  assign unused_en = en;

  always_comb begin
    for (int unsigned k = 0; k < NTERMS; k++) coef_rom[k] = coef_f(k);
  end

  always_comb begin
    xsq_d = xsq_q;
    t_d   = t_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    op    = xsel ? xsq_q : (rsel ? coef_rom[cnt_q] : ONE);

    if (ldx) xsq_d = mul_sat($signed(xbus), $signed(xbus));

    if (ld1)      t_d = ONE;
    else if (ldt) t_d = mul_sat(t_q, op);

    if (ld1)      r_d = ONE;
    else if (ldr) r_d = add_sat(r_q, t_q, addsub);

    if (ld0cnt)                        cnt_d = '0;
    else if (inccnt && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsq_q <= '0;
      t_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      xsq_q <= xsq_d;
      t_q   <= t_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

  // The most negative t has no positive magnitude; treat it as never converged.
  always_comb begin
    t_is_min = (t_q == SMIN);
    abs_t    = t_q[WIDTH-1] ? WIDTH'(-t_q) : WIDTH'(t_q);
  end

  assign TLTY    = (!t_is_min && (32'(abs_t) < THRESH)) || (cnt_q == CNT_MAX);
  assign repcnt0 = cnt_q[0];
  assign rbus    = r_q;

endmodule

// File: tb/tb_cos_datapath.sv
// Directed bench for cos_datapath: an integer model of the register rules checked every
// cycle, plus hand-computed literal expectations from the cosine walkthroughs.
module tb_cos_datapath;

  localparam logic [9:0] LDX = 10'h200, LD1 = 10'h100, LD0 = 10'h080, LDT = 10'h040;
  localparam logic [9:0] XS  = 10'h020, RS  = 10'h010, LDR = 10'h008, ADD = 10'h004;
  localparam logic [9:0] EN  = 10'h002, INC = 10'h001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] xbus;
  logic        ldx, ld1, ld0cnt, ldt, xsel, rsel, ldr, addsub, en, inccnt;
  logic        tlty, repcnt0, tlty0, repcnt0_0;
  logic [15:0] rbus, rbus0;

  int n_tests = 0;
  int n_fail  = 0;

  int m_xsq, m_t, m_r, m_cnt;
  int coef_tab [8] = '{8192, 1365, 546, 293, 182, 124, 90, 68};

  always #5 clk = ~clk;

  cos_datapath #(.WIDTH(16), .FRAC(14), .NTERMS(8), .THRESH(16)) u_dut (
    .clk(clk), .rst(rst), .xbus(xbus), .ldx(ldx), .ld1(ld1), .ld0cnt(ld0cnt),
    .ldt(ldt), .xsel(xsel), .rsel(rsel), .ldr(ldr), .addsub(addsub), .en(en),
    .inccnt(inccnt), .TLTY(tlty), .repcnt0(repcnt0), .rbus(rbus)
  );

  cos_datapath #(.WIDTH(16), .FRAC(14), .NTERMS(8), .THRESH(0)) u_dut0 (
    .clk(clk), .rst(rst), .xbus(xbus), .ldx(ldx), .ld1(ld1), .ld0cnt(ld0cnt),
    .ldt(ldt), .xsel(xsel), .rsel(rsel), .ldr(ldr), .addsub(addsub), .en(en),
    .inccnt(inccnt), .TLTY(tlty0), .repcnt0(repcnt0_0), .rbus(rbus0)
  );

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int fmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat16(p >>> 14);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference register behaviour, straight from the strobe rules.
  always @(posedge clk or posedge rst) begin : model
    int nx, nt, nr, nc, op;
    if (rst) begin
      m_xsq = 0; m_t = 0; m_r = 0; m_cnt = 0;
    end else begin
      nx = ldx ? fmul(int'($signed(xbus)), int'($signed(xbus))) : m_xsq;
      op = xsel ? m_xsq : (rsel ? coef_tab[m_cnt] : 16384);
      nt = ld1 ? 16384 : (ldt ? fmul(m_t, op) : m_t);
      nr = ld1 ? 16384 : (ldr ? sat16(addsub ? longint'(m_r + m_t) : longint'(m_r - m_t)) : m_r);
      nc = ld0cnt ? 0 : (inccnt ? ((m_cnt < 7) ? m_cnt + 1 : 7) : m_cnt);
      m_xsq = nx; m_t = nt; m_r = nr; m_cnt = nc;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rbus", int'($signed(rbus)), m_r);
      chk("repcnt0", int'(repcnt0), m_cnt % 2);
      chk("tlty", int'(tlty), int'((iabs(m_t) < 16) || (m_cnt == 7)));
      chk("tlty_thresh0", int'(tlty0), int'(m_cnt == 7));
      chk("rbus_thresh0", int'($signed(rbus0)), m_r);
    end
  end

  task automatic pulse(input logic [15:0] x, input logic [9:0] s);
    xbus = x;
    {ldx, ld1, ld0cnt, ldt, xsel, rsel, ldr, addsub, en, inccnt} = s;
    @(negedge clk);
    {ldx, ld1, ld0cnt, ldt, xsel, rsel, ldr, addsub, en, inccnt} = '0;
  endtask

  task automatic iter();
    pulse(16'h0, XS | LDT | EN);
    pulse(16'h0, RS | LDT | EN);
    pulse(16'h0, LDR | EN | (((m_cnt % 2) != 0) ? ADD : 10'h0));
    pulse(16'h0, INC | EN);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    xbus = '0;
    {ldx, ld1, ld0cnt, ldt, xsel, rsel, ldr, addsub, en, inccnt} = '0;
    repeat (2) @(negedge clk);
    chk("reset_rbus", int'(rbus), 0);
    chk("reset_tlty", int'(tlty), 1);
    chk("reset_repcnt0", int'(repcnt0), 0);
    rst = 1'b0;

    // x = 0: one iteration leaves r at 1.0
    pulse(16'h0, LDX | LD1 | LD0);
    iter();
    chk("x0_rbus", int'(rbus), 16384);
    chk("x0_repcnt0", int'(repcnt0), 1);
    chk("x0_tlty", int'(tlty), 1);

    // x = 1.0: converge toward cos(1)
    pulse(16'd16384, LDX | LD1 | LD0);
    iter();
    chk("x1_it1_rbus", int'(rbus), 8192);
    chk("x1_it1_repcnt0", int'(repcnt0), 1);
    iter();
    chk("x1_it2_rbus", int'(rbus), 8874);
    chk("x1_it2_repcnt0", int'(repcnt0), 0);
    for (int i = 0; i < 20 && !tlty; i++) iter();
    chk("x1_tlty_reached", int'(tlty), 1);
    chk("x1_cos_tol", int'(iabs(int'(rbus) - 8852) <= 4), 1);

    // x = -1.0 squares to the same magnitude
    pulse(16'hC000, LDX | LD1 | LD0);
    iter();
    chk("xm1_it1_rbus", int'(rbus), 8192);

    // Reset mid-iteration, away from any clock edge
    pulse(16'd16384, LDX | LD1 | LD0);
    pulse(16'h0, XS | LDT);
    pulse(16'h0, INC);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rbus", int'(rbus), 0);
    chk("midrst_tlty", int'(tlty), 1);
    chk("midrst_repcnt0", int'(repcnt0), 0);
    @(negedge clk);
    rst = 1'b0;

    // x = -2.0: xsq saturates, t follows
    pulse(16'h8000, LDX | LD1 | LD0);
    pulse(16'h0, XS | LDT);
    chk("sat_t_tlty", int'(tlty), 0);
    pulse(16'h0, LDR | ADD);
    chk("sat_r_rbus", int'(rbus), 32767);

    // Strobe priorities
    pulse(16'h0, LD1 | LDT | XS);
    pulse(16'h0, LDR);
    chk("ld1_over_ldt", int'(rbus), 0);
    pulse(16'h0, LDR | ADD);
    pulse(16'h0, LDR | ADD | LD1);
    chk("ld1_over_ldr", int'(rbus), 16384);
    pulse(16'h0, INC);
    chk("inc_repcnt0", int'(repcnt0), 1);
    pulse(16'h0, INC | LD0);
    chk("ld0_over_inc", int'(repcnt0), 0);

    // ldx with ldt multiplies by the previous xsq
    pulse(16'd16384, LDX | LD1);
    pulse(16'h0, LDX | XS | LDT);
    chk("old_xsq_tlty", int'(tlty), 0);
    pulse(16'h0, LDR);
    chk("old_xsq_rbus", int'(rbus), 0);

    // Counter cap with the THRESH=0 instance
    pulse(16'h0, LD0 | LD1);
    for (int i = 0; i < 12; i++) begin
      pulse(16'h0, INC | EN);
      if (i == 5) chk("cap_before_tlty0", int'(tlty0), 0);
    end
    chk("cap_repcnt0", int'(repcnt0_0), 1);
    chk("cap_tlty0", int'(tlty0), 1);
    chk("cap_tlty", int'(tlty), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
